// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry type for the instruction fetch queue
package fetch_pkg;

  localparam int XLEN     = 32;
  localparam int FQ_DEPTH = 8;

  // addi x0, x0, 0 : what decode sees when the queue has nothing to issue
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - fetch queue entry array, two write ports, one async read port
module fq_storage
  import fetch_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we0,
  input  logic [AW-1:0]   i_wa0,
  input  fq_entry_t       i_wd0,
  input  logic            i_we1,
  input  logic [AW-1:0]   i_wa1,
  input  fq_entry_t       i_wd1,
  input  logic [AW-1:0]   i_ra,
  output fq_entry_t       o_rd
);

  // Contents are qualified by the pointers/count in the parent, so no reset here.
  fq_entry_t r_mem [DEPTH];

  // Both slots of a fetch group land in the same cycle; addresses never collide
  // because the parent always drives i_wa1 = i_wa0 + 1.
  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_wa0] <= i_wd0;
    if (i_we1) r_mem[i_wa1] <= i_wd1;
  end

  assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - dual-issue-in, single-issue-out instruction fetch buffer
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  // Must match the package XLEN, which sizes the stored entry.
  parameter  int XLEN  = fetch_pkg::XLEN,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in0_valid,
  input  logic [XLEN-1:0] in0_instr,
  input  logic [XLEN-1:0] in0_pc,
  input  logic            in1_valid,
  input  logic [XLEN-1:0] in1_instr,
  input  logic [XLEN-1:0] in1_pc,
  output logic            wr_ready,
  input  logic            rd_ready,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_instr,
  output logic [XLEN-1:0] rd_pc,
  output logic [CW-1:0]   count
);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_wr_ready;
  logic          w_wr_en;
  logic          w_wr_en1;
  logic [1:0]    w_nwr;
  logic          w_rd_valid;
  logic          w_rd_fire;
  logic [PW-1:0] w_wa1;
  fq_entry_t     w_wd0;
  fq_entry_t     w_wd1;
  fq_entry_t     w_head;

  // Room for a whole group, judged from registered occupancy only, so fetch
  // never depends combinationally on decode's rd_ready.
  assign w_wr_ready = (r_count <= CW'(DEPTH - 2));

  // A lone slot 1 is malformed and dropped; slot 1 only rides along with slot 0.
  assign w_wr_en  = w_wr_ready & in0_valid & ~flush;
  assign w_wr_en1 = w_wr_en & in1_valid;
  assign w_nwr    = {w_wr_en1, w_wr_en & ~in1_valid};
  assign w_wa1    = r_wr_ptr + PW'(1);

  assign w_rd_valid = (r_count != '0) & ~flush;
  assign w_rd_fire  = w_rd_valid & rd_ready;

  assign w_wd0 = '{instr: in0_instr, pc: in0_pc};
  assign w_wd1 = '{instr: in1_instr, pc: in1_pc};

  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .i_we0 (w_wr_en),
    .i_wa0 (r_wr_ptr),
    .i_wd0 (w_wd0),
    .i_we1 (w_wr_en1),
    .i_wa1 (w_wa1),
    .i_wd1 (w_wd1),
    .i_ra  (r_rd_ptr),
    .o_rd  (w_head)
  );

  // Pointer and occupancy update; a redirect empties the queue just like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PW'(w_rd_fire);
      r_wr_ptr <= r_wr_ptr + PW'(w_nwr);
      r_count  <= r_count + CW'(w_nwr) - CW'(w_rd_fire);
    end
  end

  // Occupancy and handshake sanity checks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_count <= CW'(DEPTH));
      assert (!(w_wr_en && !w_wr_ready));
      assert (!(w_rd_fire && (r_count == '0)));
    end
  end

  assign wr_ready = w_wr_ready;
  assign rd_valid = w_rd_valid;
  assign rd_instr = w_rd_valid ? w_head.instr : XLEN'(NOP_INSTR);
  assign rd_pc    = w_rd_valid ? w_head.pc    : '0;
  assign count    = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in0_valid = 1'b0;
  logic [31:0] in0_instr = '0;
  logic [31:0] in0_pc = '0;
  logic        in1_valid = 1'b0;
  logic [31:0] in1_instr = '0;
  logic [31:0] in1_pc = '0;
  logic        wr_ready;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_instr;
  logic [31:0] rd_pc;
  logic [3:0]  count;

  int n_tests = 0;
  int n_fail  = 0;
  int m_count = 0;
  exp_t sb[$];

  fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in0_valid (in0_valid),
    .in0_instr (in0_instr),
    .in0_pc    (in0_pc),
    .in1_valid (in1_valid),
    .in1_instr (in1_instr),
    .in1_pc    (in1_pc),
    .wr_ready  (wr_ready),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_instr  (rd_instr),
    .rd_pc     (rd_pc),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc << 8) ^ 32'h00A00093;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every issued entry must be the oldest outstanding one.
  always @(negedge clk) begin
    if (!rst && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got pc 0x%08h expected no issue", rd_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rd_pc !== e.pc || rd_instr !== e.instr) begin
          n_fail++;
          $display("FAIL issue_order: got pc 0x%08h instr 0x%08h expected pc 0x%08h instr 0x%08h",
                   rd_pc, rd_instr, e.pc, e.instr);
        end
      end
    end
  end

  // One cycle of stimulus; also checks registered-state outputs against the model.
  task automatic step(input logic v0, input logic v1, input logic [31:0] pc0,
                      input logic rr, input logic fl, output logic acc);
    int n;
    logic fire;
    in0_valid = v0;
    in1_valid = v1;
    in0_pc    = pc0;
    in0_instr = instr_of(pc0);
    in1_pc    = pc0 + 32'd4;
    in1_instr = instr_of(pc0 + 32'd4);
    rd_ready  = rr;
    flush     = fl;
    #1;
    check("count", 32'(count), 32'(m_count));
    check("wr_ready", 32'(wr_ready), 32'((DEPTH - m_count) >= 2));
    check("rd_valid", 32'(rd_valid), 32'((m_count != 0) && !fl));
    if (!((m_count != 0) && !fl)) begin
      check("empty_instr", rd_instr, NOP);
      check("empty_pc", rd_pc, 32'h0);
    end
    acc  = ((DEPTH - m_count) >= 2) && v0 && !fl;
    n    = acc ? (v1 ? 2 : 1) : 0;
    fire = (m_count != 0) && !fl && rr;
    if (fl) begin
      m_count = 0;
      sb.delete();
    end else begin
      m_count = m_count + n - int'(fire);
      if (n >= 1) sb.push_back('{instr: instr_of(pc0), pc: pc0});
      if (n == 2) sb.push_back('{instr: instr_of(pc0 + 32'd4), pc: pc0 + 32'd4});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic with_flush);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    rd_ready  = 1'b0;
    flush     = with_flush;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    flush = 1'b0;
    m_count = 0;
    sb.delete();
  endtask

  task automatic idle(input logic rr, input int cycles);
    logic a;
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 32'h0, rr, 1'b0, a);
  endtask

  initial begin
    logic a;
    logic [31:0] pc;

    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and a single group read back in order.
    idle(1'b0, 1);
    step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, a);
    idle(1'b0, 1);
    idle(1'b1, 2);
    idle(1'b0, 1);

    // Fill to 6, single write to 7 (wr_ready drops), rejected group, then drain.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h10 + 32'(i * 8), 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 32'h28, 1'b0, 1'b0, a);
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, a);
    check("group_rejected_at_7", 32'(a), 32'h0);
    idle(1'b1, 8);

    // Both pointers sit at 7: the next group wraps slot 1 into index 0.
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, a);
    idle(1'b1, 3);

    // Full at exactly DEPTH with 2-entry groups.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h20 + 32'(i * 8), 1'b0, 1'b0, a);
    idle(1'b1, 9);

    // Steady state: fetch holds its PC whenever the group is not taken.
    do_reset(1'b0);
    pc = 32'h0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, pc, 1'b1, 1'b0, a);
      if (a) pc = pc + 32'd8;
    end
    idle(1'b1, 10);
    check("steady_all_issued", 32'(sb.size()), 32'h0);

    // Flush at count 5 with a colliding group and read.
    do_reset(1'b0);
    step(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, a);
    step(1'b1, 1'b1, 32'h208, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 32'h210, 1'b0, 1'b0, a);
    step(1'b1, 1'b1, 32'h300, 1'b1, 1'b1, a);
    idle(1'b0, 1);
    step(1'b1, 1'b0, 32'h400, 1'b0, 1'b0, a);
    idle(1'b1, 2);

    // Reset and flush together, mid-stream.
    step(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, a);
    do_reset(1'b1);
    idle(1'b0, 1);
    step(1'b1, 1'b1, 32'h600, 1'b0, 1'b0, a);
    idle(1'b1, 3);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Dual-issue instruction fetch buffer. It sits directly downstream of the PC/instruction-memory fetch stage and upstream of decode.
- Accepts up to two instruction/PC pairs per cycle (the dual-fetch group) and issues one per cycle, in order, to decode.
- Decouples fetch from decode stalls.
- A redirect (taken branch/jump) flushes all buffered entries.

Parameters:
- DEPTH, 8: number of entries; power of 2, minimum 4.
- XLEN, 32: instruction and PC width.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: reset; synchronous, active-high.
- flush, in, 1: redirect; discard all entries and any write this cycle.
- in0_valid, in, 1: slot 0 of fetch group valid.
- in0_instr, in, XLEN: instruction word at the group's first PC.
- in0_pc, in, XLEN: address of in0_instr.
- in1_valid, in, 1: slot 1 of fetch group valid.
- in1_instr, in, XLEN: second instruction of group.
- in1_pc, in, XLEN: address of in1_instr.
- wr_ready, out, 1: queue can accept a full 2-entry group.
- rd_ready, in, 1: decode accepts the head entry this cycle.
- rd_valid, out, 1: head entry valid.
- rd_instr, out, XLEN: head instruction; NOP when empty.
- rd_pc, out, XLEN: head PC; 0 when empty.
- count, out, $clog2(DEPTH)+1: current occupancy.

Behaviour:
- Circular buffer: registers rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH) and count.
- Reset: rd_ptr=0, wr_ptr=0, count=0 on the rst clock edge. Hence rd_valid=0, wr_ready=1, rd_instr=32'h00000013, rd_pc=0. Storage array is not reset.
- wr_ready = (DEPTH - count) >= 2, from registered count only. It ignores a same-cycle read (conservative, no combinational path from rd_ready).
- Write accept: wr_en = wr_ready & in0_valid & ~flush.
  - nwr = 1 if in1_valid=0, 2 if in1_valid=1.
  - in0 goes to wr_ptr; in1 goes to wr_ptr+1 (mod DEPTH).
  - wr_ptr advances by nwr.
  - in1_valid without in0_valid is illegal and is ignored (nwr=0).
- Group presented while wr_ready=0: not accepted. Fetch must hold the PC (stall) and re-present the group; the queue never partially accepts.
- Read: rd_valid = (count != 0) & ~flush. rd_instr/rd_pc are combinational from storage[rd_ptr].
  - rd_fire = rd_valid & rd_ready; rd_ptr advances by 1 on rd_fire.
  - When rd_valid=0, outputs are forced to NOP (32'h00000013) and 0.
- Latency: an entry written at edge N is visible on rd_* after edge N (1 cycle). No write-to-read bypass.
- Occupancy: count_next = count + nwr - rd_fire. Simultaneous read and write is legal in every state.
- Flush priority over read and write:
  - Next cycle: rd_ptr=wr_ptr=0, count=0.
  - The incoming group is dropped that cycle.
  - No rd_fire occurs in the flush cycle.
- Flush and rst asserted together: identical result (empty).
- rst mid-stream: all entries lost; the next cycle behaves exactly as after power-on reset.
- Full boundary: when count=DEPTH-1, wr_ready=0 even though one slot is free, by the 2-slot rule.
- Wrap boundary: a group written at wr_ptr=DEPTH-1 places in1 at index 0.
- Assertions:
  - count <= DEPTH.
  - No write when wr_ready=0.
  - rd_fire implies count>0.

Decomposition:
- Package fetch_pkg:
  - XLEN
  - NOP_INSTR = 32'h00000013
  - FQ_DEPTH default
  - typedef fq_entry_t struct {instr, pc}
- One sub-module: fq_storage. DEPTH x fq_entry_t register array, two write ports (addresses wa0, wa1 with enables), one asynchronous read port. No reset.
- Pointer, count and control logic stay in fetch_queue.

Test Plan:
- Reset then idle → rd_valid=0, rd_instr=0x00000013, rd_pc=0, wr_ready=1, count=0.
- Write group {pc0=0x0,pc1=0x4} with rd_ready=0 → next cycle count=2, rd_pc=0x0. Then rd_ready=1 for 2 cycles → rd_pc 0x0 then 0x4, then rd_valid=0.
- Write 2-entry groups each cycle with rd_ready=0 (DEPTH=8) → wr_ready drops after count=8. A single-entry write at count=6 gives count=7 and wr_ready=0.
- Steady state with 2-entry writes and rd_ready=1 every cycle → count rises by 1 per cycle until wr_ready=0, then alternates accept/stall. rd_pc is strictly sequential, 0x0,0x4,0x8,… with no loss or duplication.
- Wrap: advance pointers to wr_ptr=7, write {0x100,0x104} → in1 at index 0. Reads return 0x100 then 0x104.
- Flush at count=5 with a simultaneous valid group and rd_ready=1 → next cycle count=0, rd_valid=0. The dropped group is never issued. A group written after the flush is read first at rd_pc equal to its in0_pc.
